// File: rtl/ram_burst_reader.sv
// Burst read engine for the 128x8 RAM: issues sequential reads and streams the bytes out over valid/ready.
// Optional checksum output enabled by defining RAM_BURST_READER_CHECKSUM_EN.
module ram_burst_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last
`ifdef RAM_BURST_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_csum
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;

  logic              w_pop;
  logic              w_push;
  logic              w_room;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic [ADDR_W-1:0] w_issue_addr;

  // A read in flight already owns a FIFO slot, so count it as occupied.
  assign w_pop        = o_m_valid & i_m_ready;
  assign w_push       = r_inflight;
  assign w_occ        = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_room       = (w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop);
  assign w_issue      = (r_state == S_RUN) && (r_issued < r_len) && w_room && !i_rst;
  assign w_issue_addr = r_base + r_issued[ADDR_W-1:0];

  assign o_rd_addr = w_issue ? w_issue_addr : r_rd_addr;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_m_valid = (r_cnt != 2'd0);
  assign o_m_data  = r_fifo_data[r_rp];
  assign o_m_last  = r_fifo_last[r_rp] & o_m_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_base          <= '0;
      r_rd_addr       <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= '0;
      r_wp            <= 1'b0;
      r_rp            <= 1'b0;
      r_cnt           <= '0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_issued == (r_len - 1'b1));
      if (w_issue) begin
        r_issued  <= r_issued + 1'b1;
        r_rd_addr <= w_issue_addr;
      end
      // RAM output is registered: the byte for last cycle's address is on i_ram_q now.
      if (w_push) begin
        r_fifo_data[r_wp] <= i_ram_q;
        r_fifo_last[r_wp] <= r_inflight_last;
        r_wp              <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      case (r_state)
        S_IDLE: if (i_start) begin
          r_base   <= i_start_addr;
          r_len    <= i_len;
          r_issued <= '0;
          r_state  <= (i_len == '0) ? S_DONE : S_RUN;
        end
        S_RUN:   if (w_pop && o_m_last) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RAM_BURST_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  assign o_csum = r_csum;

  always_ff @(posedge i_clk) begin
    if (i_rst)                             r_csum <= '0;
    else if (r_state == S_IDLE && i_start) r_csum <= '0;
    else if (w_pop)                        r_csum <= r_csum + o_m_data;
  end
`endif

endmodule
